vga_sync_gen: RTL and testbench

Sync and pixel-coordinate generator for the 640x480 @ 60 Hz VGA path. It divides the system clock down to the pixel rate and runs the horizontal and vertical counters. It produces active-low hsync/vsync, the video_on display-area flag and the pixel_x/pixel_y coordinates consumed by the character generator downstream. It also provides a pixel tick and a frame-start strobe for other stages.

---
 rtl/vga_sync_gen_if.sv | 28 ++
 rtl/vga_sync_gen.sv | 110 +++++++++++
 tb/tb_vga_sync_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if
// Bundles the timing outputs of the VGA sync generator so that downstream
// stages (character generator, pixel pipeline) can take one port.
//   p_tick      : pixel enable, one clk in every DIV
//   pixel_x     : current horizontal count
//   pixel_y     : current vertical count
//   video_on    : high inside the visible area
//   hsync       : horizontal sync, active-low
//   vsync       : vertical sync, active-low
//   frame_start : one-clk strobe at the first pixel of each frame
// master = the generator, slave = a consumer.
interface vga_sync_gen_if;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;

    modport master (
        output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
    );

    modport slave (
        input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Sync and pixel-coordinate generator for a 640x480 @ 60 Hz VGA path.
// Divides clk down to the pixel rate, runs the horizontal and vertical
// counters and produces registered, glitch-free sync/blanking outputs that
// are aligned with the coordinates in the same cycle.
// Ports:
//   clk  : system clock, single domain
//   rst  : asynchronous, active-low reset
//   vga  : master side of vga_sync_gen_if (p_tick, pixel_x, pixel_y,
//          video_on, hsync, vsync, frame_start)
// H_DISP+H_FP+H_SYNC+H_BP and V_DISP+V_FP+V_SYNC+V_BP must not exceed 1024;
// DIV must be 1..16.
module vga_sync_gen #(
    parameter int DIV    = 4,
    parameter int H_DISP = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_DISP = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);

    // Decode bounds are 11 bits so a total of exactly 1024 cannot overflow.
    localparam logic [10:0] H_VIS_END = 11'(H_DISP);
    localparam logic [10:0] HS_BEG    = 11'(H_DISP + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_DISP + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_DISP);
    localparam logic [10:0] VS_BEG    = 11'(V_DISP + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_DISP + V_FP + V_SYNC);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [9:0]    h_cnt;
    logic [9:0]    h_nxt;
    logic [9:0]    v_cnt;
    logic [9:0]    v_nxt;
    logic          tick;
    logic          hsync_q;
    logic          vsync_q;
    logic          video_q;
    logic          hsync_d;
    logic          vsync_d;
    logic          video_d;

    // With DIV=1 div_cnt is stuck at 0 and tick is permanently high.
    assign tick = (div_cnt == DIV_LAST);

    always_comb begin
        div_nxt = tick ? '0 : div_cnt + DW'(1);
        h_nxt   = h_cnt;
        v_nxt   = v_cnt;
        if (tick) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_nxt = h_cnt + 10'd1;
            end
        end

        // Decode the next-state counters so the registered flags line up
        // with pixel_x/pixel_y in the cycle they are presented.
        hsync_d = !(({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END));
        vsync_d = !(({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END));
        video_d = ({1'b0, h_nxt} < H_VIS_END) && ({1'b0, v_nxt} < V_VIS_END);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
        end
    end

    // Strobes are gated by rst so they drop immediately on reset assertion,
    // which matters for DIV=1 where tick is high even while in reset.
    assign vga.p_tick      = rst & tick;
    assign vga.frame_start = rst & tick & (h_cnt == 10'd0) & (v_cnt == 10'd0);
    assign vga.pixel_x     = h_cnt;
    assign vga.pixel_y     = v_cnt;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// Three generator instances share clk/rst: default timing (DIV=4), default
// timing at DIV=1, and a tiny 14x7 raster at DIV=2 that completes many
// frames. Expected outputs come from the elapsed-pixel arithmetic below.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vga_sync_gen_if if0 ();
    vga_sync_gen_if if1 ();
    vga_sync_gen_if if2 ();

    vga_sync_gen u0 (
        .clk (clk),
        .rst (rst),
        .vga (if0)
    );

    vga_sync_gen #(
        .DIV (1)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .vga (if1)
    );

    vga_sync_gen #(
        .DIV    (2),
        .H_DISP (8),
        .H_FP   (2),
        .H_SYNC (2),
        .H_BP   (2),
        .V_DISP (4),
        .V_FP   (1),
        .V_SYNC (1),
        .V_BP   (1)
    ) u2 (
        .clk (clk),
        .rst (rst),
        .vga (if2)
    );

    int checks = 0;
    int errors = 0;
    bit run_checks = 1'b0;

    // Clock edges seen with rst high since the last reset.
    longint n_cyc = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) n_cyc <= 0;
        else      n_cyc <= n_cyc + 1;
    end

    // Packed as {x[9:0], y[9:0], p_tick, frame_start, hsync, vsync, video_on}
    function automatic logic [24:0] model(int div, int hd, int hf, int hs, int hb,
                                          int vd, int vf, int vs, int vb,
                                          longint n, logic r);
        longint p;
        int h, v, ht, vt;
        logic pt, fs, hsy, vsy, von;
        if (!r) return {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        p   = n / div;
        h   = int'(p % ht);
        v   = int'((p / ht) % vt);
        pt  = ((n % div) == div - 1);
        fs  = pt && (h == 0) && (v == 0);
        if (n == 0) begin
            hsy = 1'b1;
            vsy = 1'b1;
            von = 1'b0;
        end else begin
            hsy = !(h >= hd + hf && h < hd + hf + hs);
            vsy = !(v >= vd + vf && v < vd + vf + vs);
            von = (h < hd) && (v < vd);
        end
        return {10'(h), 10'(v), pt, fs, hsy, vsy, von};
    endfunction

    task automatic cmp(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_vec(string name, logic [24:0] act, logic [24:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d pt/fs/hs/vs/von=%b, expected x=%0d y=%0d pt/fs/hs/vs/von=%b at t=%0t",
                     name, act[24:15], act[14:5], act[4:0], exp[24:15], exp[14:5], exp[4:0], $time);
        end
    endtask

    task automatic check_all(string tag);
        cmp_vec({tag, " u0"},
                {if0.pixel_x, if0.pixel_y, if0.p_tick, if0.frame_start, if0.hsync, if0.vsync, if0.video_on},
                model(4, 640, 16, 96, 48, 480, 10, 2, 33, n_cyc, rst));
        cmp_vec({tag, " u1"},
                {if1.pixel_x, if1.pixel_y, if1.p_tick, if1.frame_start, if1.hsync, if1.vsync, if1.video_on},
                model(1, 640, 16, 96, 48, 480, 10, 2, 33, n_cyc, rst));
        cmp_vec({tag, " u2"},
                {if2.pixel_x, if2.pixel_y, if2.p_tick, if2.frame_start, if2.hsync, if2.vsync, if2.video_on},
                model(2, 8, 2, 2, 2, 4, 1, 1, 1, n_cyc, rst));
    endtask

    // Compare process: model check every cycle plus literal timing pins.
    int  cyc_cnt = 0;
    int  hs_run = 0;
    bit  hs_valid = 1'b0;
    bit  ln_valid = 1'b0;
    int  ln_cyc = 0;
    int  ln_y = 0;
    bit  fr_valid = 1'b0;
    int  fr_cyc = 0;

    always @(negedge clk) begin
        if (run_checks) begin
            check_all("cycle");
            cyc_cnt++;
            if (!rst) begin
                hs_valid = 1'b0;
                hs_run   = 0;
                ln_valid = 1'b0;
                fr_valid = 1'b0;
            end else begin
                cmp("u1 p_tick constant", int'(if1.p_tick), 1);
                if (!if0.hsync) begin
                    hs_run++;
                end else begin
                    if (hs_valid && hs_run != 0) cmp("u0 hsync low clks", hs_run, 384);
                    hs_valid = 1'b1;
                    hs_run   = 0;
                end
                if (if0.p_tick && if0.pixel_x == 10'd0) begin
                    if (ln_valid) begin
                        cmp("u0 line clks", cyc_cnt - ln_cyc, 3200);
                        cmp("u0 y step", int'(if0.pixel_y), (ln_y + 1) % 525);
                    end
                    ln_valid = 1'b1;
                    ln_cyc   = cyc_cnt;
                    ln_y     = int'(if0.pixel_y);
                end
                if (if2.frame_start) begin
                    if (fr_valid) cmp("u2 frame clks", cyc_cnt - fr_cyc, 196);
                    fr_valid = 1'b1;
                    fr_cyc   = cyc_cnt;
                end
                if (!if2.vsync) cmp("u2 vsync row", int'(if2.pixel_y), 5);
                if (!if2.hsync) cmp("u2 hsync col", int'(if2.pixel_x == 10'd10 || if2.pixel_x == 10'd11), 1);
            end
        end
    end

    // Offsets within the 10-unit clock period that avoid both clock edges.
    int offs [6] = '{1, 2, 3, 6, 7, 8};

    task automatic release_rst();
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic assert_rst(int off, string tag);
        @(posedge clk);
        #(off) rst = 1'b0;
        #1;
        check_all(tag);
        cmp({tag, " u0 x"}, int'(if0.pixel_x), 0);
        cmp({tag, " u0 y"}, int'(if0.pixel_y), 0);
        cmp({tag, " u0 hsync"}, int'(if0.hsync), 1);
        cmp({tag, " u0 vsync"}, int'(if0.vsync), 1);
        cmp({tag, " u0 video_on"}, int'(if0.video_on), 0);
        cmp({tag, " u1 p_tick"}, int'(if1.p_tick), 0);
    endtask

    initial begin
        int first_tick;
        int fs_at_tick;
        int found;

        #3 rst = 1'b0;
        #1 run_checks = 1'b1;
        cmp("reset u0 x", int'(if0.pixel_x), 0);
        cmp("reset u0 video_on", int'(if0.video_on), 0);
        repeat (3) @(posedge clk);
        release_rst();

        // First p_tick lands in the 4th cycle after release, with frame_start.
        first_tick = 0;
        fs_at_tick = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (if0.p_tick && first_tick == 0) begin
                first_tick = k;
                fs_at_tick = int'(if0.frame_start);
            end
        end
        cmp("u0 first p_tick cycle", first_tick, 4);
        cmp("u0 frame_start with first tick", fs_at_tick, 1);

        repeat (3 * 3200 + 100) @(posedge clk);

        // Reset in the middle of a line.
        found = 0;
        for (int i = 0; i < 5000 && found == 0; i++) begin
            @(negedge clk);
            if (if0.pixel_x == 10'd300) found = 1;
        end
        cmp("u0 reached x=300", found, 1);
        assert_rst(offs[$urandom_range(0, 5)], "midline reset");
        repeat (2) @(posedge clk);
        release_rst();

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(100, 4000)) @(posedge clk);
            assert_rst(offs[$urandom_range(0, 5)], "random reset");
            repeat ($urandom_range(1, 3)) @(posedge clk);
            release_rst();
        end

        repeat (1000) @(posedge clk);
        @(negedge clk);
        run_checks = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
